dmem_burst_master: RTL and testbench
====================================

# dmem_burst_master

Burst access initiator for the data memory port, used by the PDU to dump and load CPU data memory while the CPU is halted. Accepts a read or write burst command over a valid/ready handshake and drives the memory's word address, write data and write enable one word per cycle. It consumes the memory's same-cycle (combinational) read data and streams read words out through a registered valid/ready output. Write words are taken from a valid/ready input stream.

## Interface
- DEPTH, 10, memory word-address width; the memory holds 2^DEPTH 32-bit words
- LEN_W, 8, width of the burst length field
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  DEPTH  start word address
- cmd_len  in  LEN_W  burst length minus one (0 = 1 word)
- wd_valid  in  1  write word offered
- wd_ready  out  1  write word accepted
- wd_data  in  32  write word
- rd_valid  out  1  read word available
- rd_ready  in  1  consumer accepts read word
- rd_data  out  32  read word
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- mem_addr  out  DEPTH  memory word address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable; memory writes at posedge clk
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- State registers:
  - state: IDLE, READ or WRITE.
  - cur_addr: DEPTH bits.
  - remaining: LEN_W+1 bits, so a burst of 2^LEN_W words fits.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at a clock edge: cur_addr<=cmd_addr, remaining<=cmd_len+1, state<=cmd_write ? WRITE : READ.
- READ:
  - mem_addr=cur_addr; mem_we=0.
  - Load condition: remaining>0 and (!rd_valid or rd_ready). When it holds, at the edge: rd_data<=mem_rdata, rd_valid<=1, cur_addr<=cur_addr+1, remaining<=remaining-1.
  - remaining==0 and rd_valid and rd_ready: rd_valid<=0, state<=IDLE, done<=1.
  - rd_valid and !rd_ready: rd_data and rd_valid hold. No word is lost or duplicated.
- WRITE:
  - wd_ready = (remaining>0).
  - mem_addr=cur_addr, mem_wdata=wd_data, mem_we = wd_valid & wd_ready & !rst.
  - On a wd handshake: cur_addr++, remaining--.
  - When the handshake consumes the last word: state<=IDLE, done<=1.
- Address arithmetic is modulo 2^DEPTH: cur_addr wraps from 2^DEPTH-1 to 0 with no error.
- busy = (state != IDLE).
- done is registered, high for exactly one cycle, coincident with the first IDLE cycle.
- Outside the active state, mem_addr = cur_addr and mem_wdata = wd_data. Both are don't-care when mem_we=0.
- Reset:
  - Reset mid-burst abandons the burst: state<=IDLE, rd_valid<=0, done<=0, cur_addr<=0, remaining<=0.
  - mem_we is forced 0 during any cycle with rst high.
  - Words already written stay written.

## Timing
- Reset values: cmd_ready=1 (after the reset edge), wd_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, mem_we=0, mem_addr=0.
- Read latency: command accepted at edge E0. First mem_addr drive is in cycle E0→E1. rd_valid rises after E1.
- Read throughput: 1 word/cycle with rd_ready held high. Bubble-free under intermittent rd_ready.
- Write: zero-latency pass-through. Each wd handshake writes memory at that same edge. Throughput is 1 word/cycle.
- Completion:
  - Read of N words with no stall: N+2 cycles from cmd accept to done.
  - Write: done follows the last wd handshake by 1 cycle.
- cmd_ready is low from the accept edge until the cycle done is high. A new command is accepted in that done cycle at the earliest.

## Test plan
- Read burst, cmd_addr=0x010, cmd_len=3, rd_ready=1, mem[0x10..0x13]=A0..A3 -> rd_valid in 4 consecutive cycles starting 2 cycles after accept, data A0,A1,A2,A3. done pulses once. busy drops with done.
- Read backpressure: same burst with rd_ready toggling 1,0,0,1,0,1,1 -> exactly A0..A3 delivered in order, rd_data stable while rd_valid&!rd_ready.
- Write burst, cmd_addr=0x020, cmd_len=2, wd_data=B0,B1,B2 with one idle wd_valid cycle between B0 and B1 -> mem[0x20..0x22]=B0..B2, mem_we high exactly 3 cycles, mem[0x23] untouched.
- Wrap: write cmd_addr=0x3FE, cmd_len=3 at DEPTH=10 -> writes land at 0x3FE,0x3FF,0x000,0x001. A read back of the same range returns the same words.
- Single word and max length: read cmd_len=0 -> one word, done 3 cycles after accept. Read cmd_len=0xFF -> exactly 256 words.
- Reset mid-write after 2 of 4 words -> only 2 words written, mem_we=0 in the reset cycle, busy=0, rd_valid=0, cmd_ready=1 next cycle. A fresh command then completes normally.

Source files
------------

// File: rtl/dmem_burst_master.sv
// Burst initiator for the CPU data-memory port: one word per cycle, read data
// streamed out through a registered valid/ready stage, write data passed straight through.
module dmem_burst_master #(
  parameter int DEPTH = 10,
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_write,
  input  logic [DEPTH-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic             i_wd_valid,
  output logic             o_wd_ready,
  input  logic [31:0]      i_wd_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [31:0]      o_rd_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [DEPTH-1:0] o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic             o_mem_we,
  input  logic [31:0]      i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [LEN_W:0]   REM_ZERO = {(LEN_W+1){1'b0}};
  localparam logic [LEN_W:0]   REM_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [DEPTH-1:0] ADDR_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [DEPTH-1:0] r_cur_addr, w_cur_addr_nxt;
  logic [LEN_W:0]   r_remaining, w_remaining_nxt;
  logic             r_rd_valid, w_rd_valid_nxt;
  logic [31:0]      r_rd_data, w_rd_data_nxt;
  logic             r_done, w_done_nxt;
  logic             w_rd_load;
  logic             w_wd_hs;

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_wd_ready  = (r_state == S_WRITE) && (r_remaining != REM_ZERO);
  assign w_wd_hs     = i_wd_valid && o_wd_ready;
  // The output slot can take a new word when empty or being drained this cycle.
  assign w_rd_load   = (r_state == S_READ) && (r_remaining != REM_ZERO) &&
                       (!r_rd_valid || i_rd_ready);

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_mem_addr  = r_cur_addr;
  assign o_mem_wdata = i_wd_data;
  assign o_mem_we    = w_wd_hs && !i_rst;

  // Next-state and datapath update for the burst sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_addr_nxt  = r_cur_addr;
    w_remaining_nxt = r_remaining;
    w_rd_valid_nxt  = r_rd_valid;
    w_rd_data_nxt   = r_rd_data;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_cur_addr_nxt  = i_cmd_addr;
          w_remaining_nxt = {1'b0, i_cmd_len} + REM_ONE;
          w_state_nxt     = i_cmd_write ? S_WRITE : S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_rd_load) begin
          w_rd_data_nxt   = i_mem_rdata;
          w_rd_valid_nxt  = 1'b1;
          w_cur_addr_nxt  = r_cur_addr + ADDR_ONE;
          w_remaining_nxt = r_remaining - REM_ONE;
        end else if ((r_remaining == REM_ZERO) && r_rd_valid && i_rd_ready) begin
          w_rd_valid_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
          w_done_nxt     = 1'b1;
        end else begin
          w_rd_valid_nxt = r_rd_valid;
        end
      end
      S_WRITE: begin
        if (w_wd_hs) begin
          w_cur_addr_nxt  = r_cur_addr + ADDR_ONE;
          w_remaining_nxt = r_remaining - REM_ONE;
          if (r_remaining == REM_ONE) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= {DEPTH{1'b0}};
      r_remaining <= REM_ZERO;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= 32'h0000_0000;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_done      <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_burst_master.sv
// Directed bench for dmem_burst_master with a behavioural 1024-word memory
// (combinational read, write at posedge) and hand-computed expectations.
module tb_dmem_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wq[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign mem_rdata = mem[mem_addr];

  dmem_burst_master dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wd_valid(wd_valid), .o_wd_ready(wd_ready), .i_wd_data(wd_data),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
    .o_busy(busy), .o_done(done),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [9:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1;
    check_val("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    check_val("busy_after_accept", {31'd0, busy}, 32'd1);
    check_val("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic run_read(input logic [9:0] addr, input logic [7:0] len,
                          input logic [31:0] rdy_pat, input int pat_len,
                          input int exp_first, input int exp_done);
    int rx, first_k, done_k;
    logic stalled;
    logic [31:0] held;
    rx = 0; first_k = -1; done_k = -1; stalled = 1'b0; held = 32'h0;
    rd_ready = 1'b0;
    issue_cmd(1'b0, addr, len);
    for (int k = 1; k <= 400; k++) begin
      if (done) begin
        done_k = k;
        break;
      end
      if (stalled) begin
        check_val("rd_hold_valid", {31'd0, rd_valid}, 32'd1);
        check_val("rd_hold_data", rd_data, held);
      end
      if (rd_valid && first_k < 0) first_k = k;
      rd_ready = (k <= pat_len) ? rdy_pat[k-1] : 1'b1;
      #1;
      if (rd_valid && rd_ready) begin
        if (rx < exp_q.size()) check_val("rd_data", rd_data, exp_q[rx]);
        else check_val("rd_extra_word", 32'd1, 32'd0);
        rx++;
      end
      stalled = rd_valid && !rd_ready;
      held = rd_data;
      step();
    end
    check_val("rd_done_seen", {31'd0, done_k > 0}, 32'd1);
    check_val("rd_word_count", 32'(rx), 32'(exp_q.size()));
    if (exp_first >= 0) check_val("rd_first_valid_cycle", 32'(first_k), 32'(exp_first));
    if (exp_done >= 0) check_val("rd_done_cycle", 32'(done_k), 32'(exp_done));
    check_val("rd_busy_at_done", {31'd0, busy}, 32'd0);
    check_val("rd_cmd_ready_at_done", {31'd0, cmd_ready}, 32'd1);
    check_val("rd_valid_at_done", {31'd0, rd_valid}, 32'd0);
    step();
    check_val("rd_done_one_pulse", {31'd0, done}, 32'd0);
    rd_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_write(input logic [9:0] addr, input logic [7:0] len,
                           input logic gap, input int exp_done);
    int idx, we_cnt, done_k, n;
    logic [9:0] ea;
    idx = 0; we_cnt = 0; done_k = -1; n = int'(len) + 1;
    issue_cmd(1'b1, addr, len);
    check_val("wd_ready_first", {31'd0, wd_ready}, 32'd1);
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        done_k = k;
        break;
      end
      wd_valid = (idx < n) && !(gap && k == 2);
      wd_data  = (idx < n) ? wq[idx] : 32'h0;
      #1;
      if (mem_we) begin
        we_cnt++;
        ea = addr + 10'(idx);
        check_val("wr_mem_addr", {22'd0, mem_addr}, {22'd0, ea});
      end
      if (wd_valid && wd_ready) idx++;
      step();
    end
    wd_valid = 1'b0;
    check_val("wr_done_seen", {31'd0, done_k > 0}, 32'd1);
    check_val("wr_we_count", 32'(we_cnt), 32'(n));
    check_val("wr_done_cycle", 32'(done_k), 32'(exp_done));
    check_val("wr_busy_at_done", {31'd0, busy}, 32'd0);
    check_val("wr_wd_ready_at_done", {31'd0, wd_ready}, 32'd0);
    step();
    check_val("wr_done_one_pulse", {31'd0, done}, 32'd0);
    wq.delete();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 10'd0; cmd_len = 8'd0;
    wd_valid = 1'b0; wd_data = 32'h0; rd_ready = 1'b0;
    pre_we = 1'b0; pre_addr = 10'd0; pre_data = 32'h0;
    step();
    pre_we = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      pre_addr = 10'(i);
      pre_data = 32'hDEAD_0000 | 32'(i);
      step();
    end
    pre_we = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_wd_ready", {31'd0, wd_ready}, 32'd0);
    check_val("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_val("rst_rd_data", rd_data, 32'h0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_val("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    step();

    // read burst without stalls
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hDEAD_0010 + 32'(i));
    run_read(10'h010, 8'd3, 32'h0, 0, 2, 6);

    // same burst with ready pattern 1,0,0,1,0,1,1
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hDEAD_0010 + 32'(i));
    run_read(10'h010, 8'd3, 32'b1101001, 7, 2, 9);

    // write burst with an idle wd_valid cycle between B0 and B1
    wq.push_back(32'hB000_0000); wq.push_back(32'hB000_0001); wq.push_back(32'hB000_0002);
    run_write(10'h020, 8'd2, 1'b1, 5);
    check_val("wr_mem20", mem[10'h020], 32'hB000_0000);
    check_val("wr_mem21", mem[10'h021], 32'hB000_0001);
    check_val("wr_mem22", mem[10'h022], 32'hB000_0002);
    check_val("wr_mem23_untouched", mem[10'h023], 32'hDEAD_0023);
    check_val("wr_mem1f_untouched", mem[10'h01F], 32'hDEAD_001F);

    // wrap-around write and read back
    for (int i = 0; i < 4; i++) wq.push_back(32'hC000_0000 + 32'(i));
    run_write(10'h3FE, 8'd3, 1'b0, 5);
    check_val("wrap_mem3fe", mem[10'h3FE], 32'hC000_0000);
    check_val("wrap_mem3ff", mem[10'h3FF], 32'hC000_0001);
    check_val("wrap_mem000", mem[10'h000], 32'hC000_0002);
    check_val("wrap_mem001", mem[10'h001], 32'hC000_0003);
    check_val("wrap_mem002_untouched", mem[10'h002], 32'hDEAD_0002);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hC000_0000 + 32'(i));
    run_read(10'h3FE, 8'd3, 32'h0, 0, 2, 6);

    // single word and maximum length
    exp_q.push_back(32'hDEAD_0050);
    run_read(10'h050, 8'd0, 32'h0, 0, 2, 3);
    for (int i = 0; i < 256; i++) exp_q.push_back(32'hDEAD_0100 + 32'(i));
    run_read(10'h100, 8'hFF, 32'h0, 0, 2, 258);

    // reset after 2 of 4 write words
    issue_cmd(1'b1, 10'h200, 8'd3);
    wd_valid = 1'b1; wd_data = 32'hD000_0000;
    step();
    wd_data = 32'hD000_0001;
    step();
    wd_data = 32'hD000_0002;
    rst = 1'b1;
    #1;
    check_val("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
    step();
    rst = 1'b0;
    wd_valid = 1'b0;
    #1;
    check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_val("rst_mid_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_val("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_mid_done", {31'd0, done}, 32'd0);
    check_val("rst_mid_mem200", mem[10'h200], 32'hD000_0000);
    check_val("rst_mid_mem201", mem[10'h201], 32'hD000_0001);
    check_val("rst_mid_mem202", mem[10'h202], 32'hDEAD_0202);
    check_val("rst_mid_mem203", mem[10'h203], 32'hDEAD_0203);
    step();
    wq.push_back(32'hE000_0000); wq.push_back(32'hE000_0001);
    run_write(10'h300, 8'd1, 1'b0, 3);
    check_val("fresh_mem300", mem[10'h300], 32'hE000_0000);
    check_val("fresh_mem301", mem[10'h301], 32'hE000_0001);
    exp_q.push_back(32'hE000_0000); exp_q.push_back(32'hE000_0001);
    run_read(10'h300, 8'd1, 32'h0, 0, 2, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
